// File: rtl/dmg_oam_dma_arb.sv
// OAM DMA engine and CPU/DMA arbiter for a single shared memory bus.
// The CPU passes straight through while idle; a write to the DMA register copies DMA_LEN bytes into OAM.
module dmg_oam_dma_arb #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] OAM_BASE     = 16'hFE00
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        CPU_MREQ,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DOUT,
    output logic [7:0]  CPU_DIN,
    output logic        BUS_MREQ,
    output logic        BUS_RD,
    output logic        BUS_WR,
    output logic [15:0] BUS_A,
    output logic [7:0]  BUS_DOUT,
    input  logic [7:0]  BUS_DIN,
    output logic        DMA_ACTIVE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RD    = 2'd2,
        S_WR    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     r_state;
    logic [7:0] r_idx;
    logic [7:0] r_src;
    logic [7:0] r_dl;

    logic       w_reg_hit;
    logic       w_reg_wr;
    logic       w_reg_rd;
    logic       w_reg_acc;
    logic [7:0] w_eff_src;

    assign w_reg_hit = CPU_MREQ && (CPU_A == DMA_REG_ADDR);
    assign w_reg_wr  = w_reg_hit && CPU_WR;
    assign w_reg_rd  = w_reg_hit && CPU_RD;
    assign w_reg_acc = w_reg_wr || w_reg_rd;

    // Sources in the echo region E000-FDFF alias work RAM C000-DDFF.
    assign w_eff_src = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;

    assign DMA_ACTIVE = (r_state != S_IDLE);

    // Transfer sequencer; a register write (re)starts from any state and takes priority.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
            r_idx   <= 8'h00;
            r_src   <= 8'h00;
            r_dl    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_START: begin
                    r_state <= S_RD;
                end
                S_RD: begin
                    r_dl    <= BUS_DIN;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= S_RD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_reg_wr) begin
                r_src   <= CPU_DOUT;
                r_idx   <= 8'h00;
                r_state <= S_START;
            end
        end
    end

    // Bus and CPU read-data steering.
    always_comb begin
        BUS_MREQ = 1'b0;
        BUS_RD   = 1'b0;
        BUS_WR   = 1'b0;
        BUS_A    = 16'h0000;
        BUS_DOUT = r_dl;
        CPU_DIN  = 8'hFF;
        case (r_state)
            S_IDLE: begin
                BUS_A    = CPU_A;
                BUS_DOUT = CPU_DOUT;
                CPU_DIN  = BUS_DIN;
                if (!w_reg_acc) begin
                    BUS_MREQ = CPU_MREQ;
                    BUS_RD   = CPU_RD;
                    BUS_WR   = CPU_WR;
                end
            end
            S_RD: begin
                BUS_MREQ = 1'b1;
                BUS_RD   = 1'b1;
                BUS_A    = {w_eff_src, r_idx};
            end
            S_WR: begin
                BUS_MREQ = 1'b1;
                BUS_WR   = 1'b1;
                BUS_A    = OAM_BASE + {8'h00, r_idx};
            end
            default: begin
                BUS_A = 16'h0000;
            end
        endcase
        if (w_reg_rd) begin
            CPU_DIN = r_src;
        end
    end

endmodule

// File: tb/tb_dmg_oam_dma_arb.sv
// Bench for dmg_oam_dma_arb: a 64 KiB memory model on the shared bus, a bus-cycle log,
// and an expected-transaction list built from the transfer rules.
module tb_dmg_oam_dma_arb;

    localparam int unsigned LEN = 160;
    localparam logic [15:0] REG = 16'hFF46;
    localparam logic [15:0] OAM = 16'hFE00;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
    } xact_t;

    logic        clk;
    logic        nreset;
    logic        cpu_mreq, cpu_rd, cpu_wr;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        bus_mreq, bus_rd, bus_wr;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic        fill;
    xact_t       log_q[$];
    xact_t       exp_q[$];
    logic [7:0]  oam_exp [0:LEN-1];
    int unsigned act_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    dmg_oam_dma_arb #(
        .DMA_REG_ADDR(REG),
        .DMA_LEN     (LEN),
        .OAM_BASE    (OAM)
    ) dut (
        .CLK       (clk),
        .nRESET    (nreset),
        .CPU_MREQ  (cpu_mreq),
        .CPU_RD    (cpu_rd),
        .CPU_WR    (cpu_wr),
        .CPU_A     (cpu_a),
        .CPU_DOUT  (cpu_dout),
        .CPU_DIN   (cpu_din),
        .BUS_MREQ  (bus_mreq),
        .BUS_RD    (bus_rd),
        .BUS_WR    (bus_wr),
        .BUS_A     (bus_a),
        .BUS_DOUT  (bus_dout),
        .BUS_DIN   (bus_din),
        .DMA_ACTIVE(dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory on the shared bus: asynchronous read, write on the rising edge.
    assign bus_din = mem[bus_a];
    always @(posedge clk) begin
        if (fill) begin
            for (int a = 0; a < 65536; a++) mem[a] <= 8'($urandom);
        end else if (bus_mreq && bus_wr) begin
            mem[bus_a] <= bus_dout;
        end
    end

    // Record every bus cycle and every DMA-active cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_mreq) log_q.push_back(xact_t'({bus_wr, bus_a, (bus_wr ? bus_dout : bus_din)}));
        if (dma_active) act_cnt <= act_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    task automatic cpu_set(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_mreq = 1'b1;
        cpu_rd   = rd;
        cpu_wr   = wr;
        cpu_a    = a;
        cpu_dout = d;
    endtask

    // Expected transfer: every byte is read from the (echo-corrected) source page, then written to OAM.
    task automatic build(input logic [7:0] src, input int n);
        logic [7:0]  page;
        logic [15:0] sa;
        page = (src >= 8'hE0) ? 8'(src - 8'h20) : src;
        for (int i = 0; i < n; i++) begin
            sa = {page, 8'(i)};
            exp_q.push_back(xact_t'({1'b0, sa, mem[sa]}));
            exp_q.push_back(xact_t'({1'b1, 16'(OAM + 16'(i)), mem[sa]}));
            oam_exp[i] = mem[sa];
        end
    endtask

    function automatic int seq_mismatches(input int start);
        int bad;
        int got;
        bad = 0;
        got = log_q.size() - start;
        if (got != exp_q.size()) bad++;
        for (int k = 0; k < exp_q.size() && k < got; k++)
            if (log_q[start + k] !== exp_q[k]) bad++;
        return bad;
    endfunction

    function automatic int oam_mismatches();
        int bad;
        bad = 0;
        for (int i = 0; i < LEN; i++)
            if (mem[16'(OAM + 16'(i))] !== oam_exp[i]) bad++;
        return bad;
    endfunction

    task automatic wait_done(output logic timed_out);
        int n;
        n = 0;
        while (dma_active && n < 2000) begin
            tick();
            n++;
        end
        timed_out = dma_active;
    endtask

    task automatic test_reset();
        cpu_idle();
        nreset = 1'b0;
        fill   = 1'b1;
        #1;
        n_tests++;
        if (dma_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active: got %b want 0", dma_active);
        end
        tick();
        fill = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
        cpu_set(1'b1, 1'b0, REG, 8'h00);
        #1;
        n_tests++;
        if (cpu_din !== 8'h00 || bus_mreq !== 1'b0 || bus_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regread: din=%h mreq=%b rd=%b want din=00 mreq=0 rd=0", cpu_din, bus_mreq, bus_rd);
        end
        tick();
        cpu_idle();
    endtask

    task automatic test_passthrough();
        logic        rd;
        logic [15:0] a;
        logic [7:0]  d;
        cpu_set(1'b0, 1'b1, 16'hC000, 8'h3C);
        #1;
        n_tests++;
        if (bus_mreq !== 1'b1 || bus_wr !== 1'b1 || bus_a !== 16'hC000 || bus_dout !== 8'h3C) begin
            n_fail++;
            $display("FAIL pass_write: mreq=%b wr=%b a=%h d=%h want 1 1 c000 3c", bus_mreq, bus_wr, bus_a, bus_dout);
        end
        tick();
        cpu_set(1'b1, 1'b0, 16'hC000, 8'h00);
        #1;
        n_tests++;
        if (bus_rd !== 1'b1 || bus_a !== 16'hC000 || cpu_din !== 8'h3C) begin
            n_fail++;
            $display("FAIL pass_read: rd=%b a=%h din=%h want 1 c000 3c", bus_rd, bus_a, cpu_din);
        end
        tick();
        for (int t = 0; t < 10; t++) begin
            rd = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            if (a == REG) a = 16'h8000;
            d  = 8'($urandom);
            cpu_set(rd, !rd, a, d);
            #1;
            n_tests++;
            if ({bus_mreq, bus_rd, bus_wr, bus_a, bus_dout} !== {1'b1, rd, !rd, a, d} ||
                (rd && cpu_din !== mem[a])) begin
                n_fail++;
                $display("FAIL pass_rand%0d: mreq=%b rd=%b wr=%b a=%h do=%h din=%h want 1 %b %b %h %h din=%h",
                         t, bus_mreq, bus_rd, bus_wr, bus_a, bus_dout, cpu_din, rd, !rd, a, d, mem[a]);
            end
            tick();
        end
        cpu_idle();
    endtask

    task automatic test_transfer(input logic [7:0] src);
        int          start;
        int unsigned a0;
        logic        to;
        int          bad;
        exp_q.delete();
        build(src, LEN);
        start = log_q.size();
        a0    = act_cnt;
        cpu_set(1'b0, 1'b1, REG, src);
        tick();
        cpu_idle();
        #1;
        n_tests++;
        if (dma_active !== 1'b1 || bus_mreq !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle_%h: active=%b mreq=%b want 1 0", src, dma_active, bus_mreq);
        end
        wait_done(to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL done_%h: transfer still active after bound, want idle", src);
        end
        n_tests++;
        if (act_cnt - a0 !== 1 + 2 * LEN) begin
            n_fail++;
            $display("FAIL active_len_%h: got %0d want %0d", src, act_cnt - a0, 1 + 2 * LEN);
        end
        bad = seq_mismatches(start);
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bus_seq_%h: %0d bad entries, want 0", src, bad);
        end
        bad = oam_mismatches();
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL oam_%h: %0d bad bytes, want 0", src, bad);
        end
        cpu_set(1'b1, 1'b0, REG, 8'h00);
        #1;
        n_tests++;
        if (cpu_din !== src) begin
            n_fail++;
            $display("FAIL readback_%h: got %h want %h", src, cpu_din, src);
        end
        tick();
        cpu_idle();
    endtask

    task automatic test_blocked();
        int         start;
        logic       to;
        logic [7:0] old;
        int         bad;
        exp_q.delete();
        build(8'hC1, LEN);
        start = log_q.size();
        cpu_set(1'b0, 1'b1, REG, 8'hC1);
        tick();
        cpu_idle();
        repeat (5) tick();
        cpu_set(1'b1, 1'b0, 16'h8000, 8'h00);
        #1;
        n_tests++;
        if (cpu_din !== 8'hFF) begin
            n_fail++;
            $display("FAIL blocked_read: got %h want ff", cpu_din);
        end
        tick();
        old = mem[16'h9000];
        cpu_set(1'b0, 1'b1, 16'h9000, ~old);
        tick();
        cpu_idle();
        wait_done(to);
        n_tests++;
        if (to || mem[16'h9000] !== old) begin
            n_fail++;
            $display("FAIL blocked_write: timeout=%b mem9000=%h want timeout=0 mem9000=%h", to, mem[16'h9000], old);
        end
        bad = seq_mismatches(start);
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL blocked_seq: %0d bad entries, want 0", bad);
        end
        bad = oam_mismatches();
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL blocked_oam: %0d bad bytes, want 0", bad);
        end
    endtask

    task automatic test_restart();
        int          start;
        int unsigned a0;
        logic        to;
        int          bad;
        exp_q.delete();
        build(8'hC1, 50);
        build(8'hD0, LEN);
        start = log_q.size();
        a0    = act_cnt;
        cpu_set(1'b0, 1'b1, REG, 8'hC1);
        tick();
        cpu_idle();
        repeat (100) tick();
        // Cycle 101 of the transfer is the OAM write of byte 49.
        n_tests++;
        if (bus_wr !== 1'b1 || bus_a !== 16'hFE31) begin
            n_fail++;
            $display("FAIL restart_pos: wr=%b a=%h want 1 fe31", bus_wr, bus_a);
        end
        cpu_set(1'b0, 1'b1, REG, 8'hD0);
        tick();
        cpu_idle();
        wait_done(to);
        n_tests++;
        if (to || act_cnt - a0 !== 101 + 1 + 2 * LEN) begin
            n_fail++;
            $display("FAIL restart_len: timeout=%b got %0d want %0d", to, act_cnt - a0, 101 + 1 + 2 * LEN);
        end
        bad = seq_mismatches(start);
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL restart_seq: %0d bad entries, want 0", bad);
        end
        bad = oam_mismatches();
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL restart_oam: %0d bad bytes, want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int          start;
        int unsigned a0;
        cpu_set(1'b0, 1'b1, REG, 8'hC1);
        tick();
        cpu_idle();
        repeat (21) tick();
        n_tests++;
        if (bus_rd !== 1'b1 || bus_a !== 16'hC10A) begin
            n_fail++;
            $display("FAIL midrst_pos: rd=%b a=%h want 1 c10a", bus_rd, bus_a);
        end
        nreset = 1'b0;
        #1;
        n_tests++;
        if (dma_active !== 1'b0 || bus_mreq !== 1'b0 || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: active=%b mreq=%b rd=%b wr=%b want 0 0 0 0", dma_active, bus_mreq, bus_rd, bus_wr);
        end
        tick();
        tick();
        nreset = 1'b1;
        start = log_q.size();
        a0    = act_cnt;
        repeat (50) tick();
        n_tests++;
        if (log_q.size() !== start || act_cnt !== a0) begin
            n_fail++;
            $display("FAIL midrst_quiet: bus cycles=%0d active cycles=%0d want 0 0", log_q.size() - start, act_cnt - a0);
        end
        cpu_set(1'b1, 1'b0, REG, 8'h00);
        #1;
        n_tests++;
        if (cpu_din !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_reg: got %h want 00", cpu_din);
        end
        tick();
        cpu_idle();
    endtask

    initial begin
        nreset = 1'b0;
        fill   = 1'b0;
        cpu_idle();
        test_reset();
        test_passthrough();
        test_transfer(8'hC1);
        test_transfer(8'hE2);
        test_transfer(8'(8'hC0 + $urandom_range(0, 31)));
        test_blocked();
        test_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
